// File: rtl/vdma_rd_frame_scheduler_pkg.sv
// rtl/vdma_rd_frame_scheduler_pkg.sv - shared VDMA read scheduler types and helpers
package vdma_rd_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRM,
    ST_SELECT,
    ST_BURST,
    ST_INFLT,
    ST_NEXT,
    ST_LWAIT
  } state_t;

  localparam logic [12:0] BOUNDARY_4K = 13'h1000;

  function automatic int beat_shift(input int bytes);
    return $clog2(bytes);
  endfunction

  // Buffer the writer finished most recently: (wr - 1) mod frame_num.
  function automatic logic [1:0] prev_buf(input logic [1:0] wr, input int frame_num);
    int v;
    if (frame_num <= 1) return 2'd0;
    v = (int'(wr) + frame_num - 1) % frame_num;
    return 2'(v);
  endfunction

endpackage

// File: rtl/vdma_rd_frame_scheduler_burst_splitter.sv
// rtl/vdma_rd_frame_scheduler_burst_splitter.sv - burst size from address and bytes left
module vdma_rd_frame_scheduler_burst_splitter
  import vdma_rd_frame_scheduler_pkg::*;
#(
  parameter int BEAT_BYTES = 4,
  parameter int MAX_BEATS  = 256
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] addr_lo,
  input  logic [16:0] bytes_left,
  output logic [8:0]  beats,
  output logic [7:0]  len
);

  localparam int SHIFT = beat_shift(BEAT_BYTES);

  logic [16:0] rem_beats;
  logic [16:0] bnd_beats;
  logic [16:0] pick;

  always_comb begin
    rem_beats = bytes_left >> SHIFT;
    bnd_beats = 17'((BOUNDARY_4K - {1'b0, addr_lo}) >> SHIFT);
    if (bnd_beats == 17'd0) bnd_beats = 17'd1;
    pick = rem_beats;
    if (pick > 17'(MAX_BEATS)) pick = 17'(MAX_BEATS);
    if (pick > bnd_beats) pick = bnd_beats;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      beats <= '0;
      len   <= '0;
    end else if (load) begin
      beats <= pick[8:0];
      len   <= 8'(pick - 17'd1);
    end
  end

endmodule

// File: rtl/vdma_rd_frame_scheduler.sv
// rtl/vdma_rd_frame_scheduler.sv - turns stream alignment pulses into AXI read burst requests
module vdma_rd_frame_scheduler
  import vdma_rd_frame_scheduler_pkg::*;
#(
  parameter int ASIZE      = 32,
  parameter int BEAT_BYTES = 4,
  parameter int MAX_BEATS  = 256,
  parameter int FRAME_NUM  = 3,
  parameter     MODE       = "LINE"
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic [ASIZE-1:0] frame_base,
  input  logic [ASIZE-1:0] frame_size,
  input  logic [15:0]      line_bytes,
  input  logic [15:0]      vactive,
  input  logic [1:0]       wr_buf_idx,
  input  logic             falign,
  input  logic             lalign,
  input  logic             ealign,
  output logic             req,
  output logic [ASIZE-1:0] req_addr,
  output logic [7:0]       req_len,
  input  logic             req_ack,
  input  logic             rd_done,
  output logic [1:0]       rd_buf_idx,
  output logic             busy,
  output logic             underrun,
  output logic             frame_drop
);

  localparam int SHIFT     = beat_shift(BEAT_BYTES);
  localparam bit LINE_MODE = (MODE == "LINE");

  state_t           state, next_state;
  logic [ASIZE-1:0] line_addr, cur_addr, sel_base;
  logic [16:0]      bytes_left, lbr, step;
  logic [15:0]      lcnt;
  logic [1:0]       sel_idx;
  logic [8:0]       sp_beats;
  logic             falign_pend, abort_pend, lalign_pend;
  logic             req_set, adv_line, line_done, last_line, frame_complete, in_frame;
  logic             lalign_ev, underrun_ev, drop_ev, clear_pend;

  always_comb begin
    lbr      = ({1'b0, line_bytes} + 17'(BEAT_BYTES - 1)) & ~17'(BEAT_BYTES - 1);
    step     = 17'(sp_beats) << SHIFT;
    sel_idx  = prev_buf(wr_buf_idx, FRAME_NUM);
    sel_base = frame_base + ASIZE'(sel_idx) * frame_size;
  end

  always_comb begin
    line_done      = (bytes_left == 17'd0);
    last_line      = (({1'b0, lcnt} + 17'd1) >= {1'b0, vactive});
    in_frame       = state inside {ST_BURST, ST_INFLT, ST_NEXT, ST_LWAIT};
    frame_complete = line_done && last_line &&
                     ((state == ST_NEXT) || (state == ST_INFLT && rd_done));
    lalign_ev      = LINE_MODE && lalign &&
                     ((state == ST_BURST) ||
                      (state == ST_INFLT && !(rd_done && line_done)) ||
                      (state == ST_NEXT && !line_done));
    underrun_ev    = lalign_ev || (ealign && in_frame && !frame_complete);
    drop_ev        = falign && in_frame && !frame_complete;
    busy           = (state == ST_SELECT) || in_frame;
  end

  // Abort paths (falign, ealign, enable low) are only taken with no burst outstanding.
  always_comb begin
    next_state = state;
    req_set    = 1'b0;
    case (state)
      ST_IDLE:     if (enable) next_state = ST_WAIT_FRM;
      ST_WAIT_FRM: if (!enable) next_state = ST_IDLE;
                   else if (falign) next_state = ST_SELECT;
      ST_SELECT:   if (!enable) next_state = ST_IDLE;
                   else if (vactive == 16'd0 || lbr == 17'd0) next_state = ST_WAIT_FRM;
                   else next_state = ST_BURST;
      ST_BURST: begin
        if (req) begin
          if (req_ack) next_state = ST_INFLT;
        end else if (!enable) next_state = ST_IDLE;
        else if (falign || falign_pend) next_state = ST_SELECT;
        else if (ealign || abort_pend) next_state = ST_WAIT_FRM;
        else req_set = 1'b1;
      end
      ST_INFLT:    if (rd_done) next_state = ST_NEXT;
      ST_NEXT: begin
        if (!enable) next_state = ST_IDLE;
        else if (falign || falign_pend) next_state = ST_SELECT;
        else if (ealign || abort_pend) next_state = ST_WAIT_FRM;
        else if (!line_done) next_state = ST_BURST;
        else if (!last_line)
          next_state = (!LINE_MODE || lalign || lalign_pend) ? ST_BURST : ST_LWAIT;
        else next_state = ST_WAIT_FRM;
      end
      ST_LWAIT: begin
        if (!enable) next_state = ST_IDLE;
        else if (falign || falign_pend) next_state = ST_SELECT;
        else if (ealign || abort_pend) next_state = ST_WAIT_FRM;
        else if (lalign) next_state = ST_BURST;
      end
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    adv_line   = (state == ST_NEXT) && line_done && !last_line &&
                 (next_state == ST_BURST || next_state == ST_LWAIT);
    clear_pend = next_state inside {ST_SELECT, ST_WAIT_FRM, ST_IDLE};
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      req         <= 1'b0;
      req_addr    <= '0;
      rd_buf_idx  <= '0;
      line_addr   <= '0;
      cur_addr    <= '0;
      bytes_left  <= '0;
      lcnt        <= '0;
      falign_pend <= 1'b0;
      abort_pend  <= 1'b0;
      lalign_pend <= 1'b0;
      underrun    <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      underrun   <= underrun_ev;
      frame_drop <= drop_ev;

      if (state == ST_SELECT) begin
        rd_buf_idx <= sel_idx;
        line_addr  <= sel_base;
        cur_addr   <= sel_base;
        bytes_left <= lbr;
        lcnt       <= '0;
      end

      if (req_set) begin
        req      <= 1'b1;
        req_addr <= cur_addr;
      end else if (req && req_ack) begin
        req        <= 1'b0;
        cur_addr   <= cur_addr + ASIZE'(step);
        bytes_left <= bytes_left - step;
      end

      if (adv_line) begin
        lcnt       <= lcnt + 16'd1;
        line_addr  <= line_addr + ASIZE'(lbr);
        cur_addr   <= line_addr + ASIZE'(lbr);
        bytes_left <= lbr;
      end

      if (clear_pend) falign_pend <= 1'b0;
      else if (falign && (state == ST_BURST || state == ST_INFLT)) falign_pend <= 1'b1;

      if (clear_pend) abort_pend <= 1'b0;
      else if (ealign && in_frame && !frame_complete) abort_pend <= 1'b1;

      if (clear_pend || adv_line) lalign_pend <= 1'b0;
      else if (lalign_ev) lalign_pend <= 1'b1;
    end
  end

  vdma_rd_frame_scheduler_burst_splitter #(
    .BEAT_BYTES(BEAT_BYTES),
    .MAX_BEATS (MAX_BEATS)
  ) u_splitter (
    .clock     (clock),
    .rst       (rst),
    .load      (req_set),
    .addr_lo   (cur_addr[11:0]),
    .bytes_left(bytes_left),
    .beats     (sp_beats),
    .len       (req_len)
  );

endmodule

// File: tb/tb_vdma_rd_frame_scheduler.sv
// tb/tb_vdma_rd_frame_scheduler.sv - directed self-checking bench for the read frame scheduler
module tb_vdma_rd_frame_scheduler;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] frame_base = '0;
  logic [31:0] frame_size = '0;
  logic [15:0] line_bytes = '0;
  logic [15:0] vactive = '0;
  logic [1:0]  wr_buf_idx = '0;
  logic        falign = 1'b0;
  logic        lalign = 1'b0;
  logic        ealign = 1'b0;
  logic        req;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        req_ack = 1'b0;
  logic        rd_done = 1'b0;
  logic [1:0]  rd_buf_idx;
  logic        busy;
  logic        underrun;
  logic        frame_drop;

  int n_tests = 0;
  int n_fail = 0;

  vdma_rd_frame_scheduler dut (
    .clock     (clock),
    .rst       (rst),
    .enable    (enable),
    .frame_base(frame_base),
    .frame_size(frame_size),
    .line_bytes(line_bytes),
    .vactive   (vactive),
    .wr_buf_idx(wr_buf_idx),
    .falign    (falign),
    .lalign    (lalign),
    .ealign    (ealign),
    .req       (req),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ack   (req_ack),
    .rd_done   (rd_done),
    .rd_buf_idx(rd_buf_idx),
    .busy      (busy),
    .underrun  (underrun),
    .frame_drop(frame_drop)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    falign = 1'b0;
    lalign = 1'b0;
    ealign = 1'b0;
    req_ack = 1'b0;
    rd_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic setup(input logic [31:0] base, input logic [31:0] size, input logic [15:0] lb,
                       input logic [15:0] va, input logic [1:0] wr);
    frame_base = base;
    frame_size = size;
    line_bytes = lb;
    vactive    = va;
    wr_buf_idx = wr;
  endtask

  task automatic start_frame();
    enable = 1'b1;
    tick();
    falign = 1'b1;
    tick();
    falign = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 64'(req), 64'd1);
  endtask

  task automatic burst(input string tag, input logic [31:0] addr, input logic [7:0] len);
    wait_req(tag);
    check({tag, "_addr"}, 64'(req_addr), 64'(addr));
    check({tag, "_len"}, 64'(req_len), 64'(len));
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    check({tag, "_req_drop"}, 64'(req), 64'd0);
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  task automatic quiet(input string tag, input int n);
    int c;
    c = 0;
    repeat (n) begin
      tick();
      if (req) c++;
    end
    check({tag, "_no_req"}, 64'(c), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    check("rst_req", 64'(req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_idx", 64'(rd_buf_idx), 64'd0);
    check("rst_len", 64'(req_len), 64'd0);
    check("rst_pulses", 64'({underrun, frame_drop}), 64'd0);

    // Two 64-byte lines, LINE mode; second released by lalign.
    setup(32'h1000, 32'h10000, 16'd64, 16'd2, 2'd1);
    start_frame();
    burst("t1_l0", 32'h1000, 8'd15);
    check("t1_idx", 64'(rd_buf_idx), 64'd0);
    quiet("t1_lwait", 4);
    check("t1_busy", 64'(busy), 64'd1);
    lalign = 1'b1;
    tick();
    lalign = 1'b0;
    burst("t1_l1", 32'h1040, 8'd15);
    quiet("t1_end", 4);
    check("t1_idle", 64'(busy), 64'd0);

    // 2048-byte line splits at MAX_BEATS.
    do_reset();
    setup(32'h0, 32'h10000, 16'd2048, 16'd1, 2'd1);
    start_frame();
    burst("t2_b0", 32'h0, 8'd255);
    burst("t2_b1", 32'h400, 8'd255);
    quiet("t2_end", 4);

    // Line straddling a 4 KB boundary.
    do_reset();
    setup(32'h0F80, 32'h10000, 16'd256, 16'd1, 2'd1);
    start_frame();
    burst("t3_b0", 32'h0F80, 8'd31);
    burst("t3_b1", 32'h1000, 8'd31);
    quiet("t3_end", 4);

    // Buffer select wraps: writer on 0 -> read buffer 2.
    do_reset();
    setup(32'h100, 32'h10000, 16'd64, 16'd1, 2'd0);
    start_frame();
    burst("t4", 32'h20100, 8'd15);
    check("t4_idx", 64'(rd_buf_idx), 64'd2);

    // falign while a burst is in flight.
    do_reset();
    setup(32'h1000, 32'h10000, 16'd64, 16'd2, 2'd1);
    start_frame();
    wait_req("t5_first");
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    falign = 1'b1;
    tick();
    falign = 1'b0;
    check("t5_drop", 64'(frame_drop), 64'd1);
    tick();
    check("t5_drop_clr", 64'(frame_drop), 64'd0);
    quiet("t5_drain", 3);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    burst("t5_new", 32'h1000, 8'd15);

    // Async reset while req is high.
    do_reset();
    setup(32'h0, 32'h10000, 16'd64, 16'd2, 2'd0);
    start_frame();
    wait_req("t6_pre");
    check("t6_idx_pre", 64'(rd_buf_idx), 64'd2);
    rst = 1'b1;
    #1;
    check("t6_rst_req", 64'(req), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_idx", 64'(rd_buf_idx), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Early ealign after line 0 of 2.
    start_frame();
    burst("t7_l0", 32'h20000, 8'd15);
    tick();
    ealign = 1'b1;
    tick();
    ealign = 1'b0;
    check("t7_underrun", 64'(underrun), 64'd1);
    tick();
    check("t7_underrun_clr", 64'(underrun), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    quiet("t7_end", 3);

    // lalign during an in-flight line: underrun, then next line issued without waiting.
    do_reset();
    setup(32'h1000, 32'h10000, 16'd64, 16'd2, 2'd1);
    start_frame();
    wait_req("t8_l0");
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    lalign = 1'b1;
    tick();
    lalign = 1'b0;
    check("t8_underrun", 64'(underrun), 64'd1);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    burst("t8_l1", 32'h1040, 8'd15);

    // vactive == 0: no request at all.
    do_reset();
    setup(32'h1000, 32'h10000, 16'd64, 16'd0, 2'd1);
    start_frame();
    quiet("t9", 6);
    check("t9_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
